// File: rtl/pe_pkg.sv
// Shared definitions for the processing-element family.
//   - acc_width_ok : elaboration-time check of the accumulator width
//   - round_sat    : round-half-up and saturate a wide signed sum to BW bits
//   - rs_t         : round/saturate result {data, sat}
package pe_pkg;

  // Widest sum and result that round_sat handles. Callers sign-extend into
  // RS_MAX_W and take the low BW bits of data.
  localparam int RS_MAX_W  = 128;
  localparam int RS_DATA_W = 64;

  typedef struct packed {
    logic [RS_DATA_W-1:0] data;
    logic                 sat;
  } rs_t;

  // The accumulator must hold K_MAX full-scale products without wrapping.
  function automatic bit acc_width_ok(input int accw, input int bw, input int k_max);
    return (accw >= 2 * bw + $clog2(k_max)) && (accw <= RS_MAX_W) && (bw < RS_DATA_W);
  endfunction

  // sum is a signed fixed-point value with 2*frac fractional bits. Rounds
  // half-up to frac fractional bits, then clamps to the signed bw-bit range.
  function automatic rs_t round_sat(input logic signed [RS_MAX_W-1:0] sum,
                                    input int bw, input int frac);
    logic signed [RS_MAX_W-1:0] half;
    logic signed [RS_MAX_W-1:0] r;
    logic signed [RS_MAX_W-1:0] hi;
    logic signed [RS_MAX_W-1:0] lo;
    rs_t res;
    half = 128'sd1 <<< (frac - 1);
    r    = (sum + half) >>> frac;
    hi   = (128'sd1 <<< (bw - 1)) - 128'sd1;
    lo   = -(128'sd1 <<< (bw - 1));
    res.sat = 1'b0;
    if (r > hi) begin
      res.data = hi[RS_DATA_W-1:0];
      res.sat  = 1'b1;
    end else if (r < lo) begin
      res.data = lo[RS_DATA_W-1:0];
      res.sat  = 1'b1;
    end else begin
      res.data = r[RS_DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/pe_round_sat.sv
// Combinational ACCW -> BW round-half-up and saturate.
//   sum  : signed accumulator value, 2*FRAC fractional bits
//   data : rounded, clamped BW-bit result, FRAC fractional bits
//   sat  : the clamp changed the value
module pe_round_sat
  import pe_pkg::*;
#(
  parameter int BW   = 16,
  parameter int FRAC = 15,
  parameter int ACCW = 48
) (
  input  logic signed [ACCW-1:0] sum,
  output logic        [BW-1:0]   data,
  output logic                   sat
);

  rs_t  rs;
  logic unused_hi;

  // Size cast of a signed operand sign-extends.
  assign rs        = round_sat(RS_MAX_W'(sum), BW, FRAC);
  assign data      = rs.data[BW-1:0];
  assign sat       = rs.sat;
  assign unused_hi = ^rs.data[RS_DATA_W-1:BW];

endmodule

// File: rtl/pe_kmac.sv
// Systolic processing element with a programmable-length dot product.
//   clk, rst              : clock, async active-high reset
//   a_in, b_in, in_valid  : operand pair from west / north
//   a_out, b_out, out_valid : operands registered and forwarded east / south
//   acc_clr               : abort the current tile, clear ovf_err
//   k_len                 : products per tile (0 -> 1, clamp at K_MAX)
//   res_data, res_sat, res_valid, res_ready : one-entry result port
//   ovf_err               : sticky, a completed result was dropped
//   busy                  : tile in progress
module pe_kmac
  import pe_pkg::*;
#(
  parameter int BW    = 16,
  parameter int FRAC  = 15,
  parameter int K_MAX = 64,
  parameter int ACCW  = 48,
  parameter int KW    = $clog2(K_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] a_in,
  input  logic [BW-1:0] b_in,
  input  logic          in_valid,
  output logic [BW-1:0] a_out,
  output logic [BW-1:0] b_out,
  output logic          out_valid,
  input  logic          acc_clr,
  input  logic [KW-1:0] k_len,
  output logic [BW-1:0] res_data,
  output logic          res_sat,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          ovf_err,
  output logic          busy
);

  if (!acc_width_ok(ACCW, BW, K_MAX)) begin : g_bad_accw
    $error("pe_kmac: ACCW too small for BW and K_MAX");
  end
  if (FRAC < 1 || FRAC > BW - 1) begin : g_bad_frac
    $error("pe_kmac: FRAC out of range");
  end

  logic signed [BW-1:0]   a_reg;
  logic signed [BW-1:0]   b_reg;
  logic                   v_reg;
  logic signed [ACCW-1:0] acc;
  logic        [KW-1:0]   cnt;
  logic        [KW-1:0]   k_lat;

  logic signed [2*BW-1:0] prod;
  logic signed [ACCW-1:0] sum;
  logic        [KW-1:0]   k_eff;
  logic        [KW-1:0]   k_cur;
  logic                   last;
  logic                   done;
  logic        [BW-1:0]   rs_data;
  logic                   rs_sat;

  assign prod = a_reg * b_reg;
  assign sum  = acc + ACCW'(prod);

  // NOTE: every always_comb output gets a value on every path; a missing
  // branch would infer a latch.
  always_comb begin
    if (k_len == '0)                k_eff = KW'(1);
    else if (k_len > KW'(K_MAX))    k_eff = KW'(K_MAX);
    else                            k_eff = k_len;
    // The first product of a tile uses the live k_len; later ones use the
    // value latched with that first product.
    k_cur = (cnt == '0) ? k_eff : k_lat;
  end

  assign last = (cnt == k_cur - KW'(1));
  assign done = v_reg && !acc_clr && last;

  pe_round_sat #(.BW(BW), .FRAC(FRAC), .ACCW(ACCW)) u_round_sat (
    .sum  (sum),
    .data (rs_data),
    .sat  (rs_sat)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      v_reg     <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      k_lat     <= KW'(1);
      res_data  <= '0;
      res_sat   <= 1'b0;
      res_valid <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      a_reg <= a_in;
      b_reg <= b_in;
      v_reg <= in_valid;

      if (acc_clr) begin
        acc     <= '0;
        cnt     <= '0;
        ovf_err <= 1'b0;
      end else if (v_reg) begin
        if (cnt == '0) k_lat <= k_eff;
        if (last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + KW'(1);
        end
      end

      // Completion with a full, stalled holding register drops the new
      // result; the held one is never overwritten.
      if (done) begin
        if (!res_valid || res_ready) begin
          res_data  <= rs_data;
          res_sat   <= rs_sat;
          res_valid <= 1'b1;
        end else begin
          ovf_err <= 1'b1;
        end
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign a_out     = a_reg;
  assign b_out     = b_reg;
  assign out_valid = v_reg;
  assign busy      = (cnt != '0);

endmodule

// File: tb/tb_pe_kmac.sv
// Scoreboard bench for pe_kmac (BW=16, FRAC=15). Expected results are pushed
// when the last product of a tile is issued; a monitor pops and compares on
// every res_valid && res_ready handshake.
module tb_pe_kmac;

  localparam int BW    = 16;
  localparam int FRAC  = 15;
  localparam int K_MAX = 64;
  localparam int ACCW  = 48;
  localparam int KW    = $clog2(K_MAX + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] a_in, b_in;
  logic          in_valid;
  logic [BW-1:0] a_out, b_out;
  logic          out_valid;
  logic          acc_clr;
  logic [KW-1:0] k_len;
  logic [BW-1:0] res_data;
  logic          res_sat, res_valid, res_ready, ovf_err, busy;

  pe_kmac #(.BW(BW), .FRAC(FRAC), .K_MAX(K_MAX), .ACCW(ACCW), .KW(KW)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a_in),
    .b_in      (b_in),
    .in_valid  (in_valid),
    .a_out     (a_out),
    .b_out     (b_out),
    .out_valid (out_valid),
    .acc_clr   (acc_clr),
    .k_len     (k_len),
    .res_data  (res_data),
    .res_sat   (res_sat),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .ovf_err   (ovf_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {sat, data}
  logic [BW:0] exp_q[$];
  logic [BW:0] exp_item;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Outputs change at posedge; sample at negedge, where res_ready is stable.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h, expected none", {res_sat, res_data});
      end else begin
        exp_item = exp_q.pop_front();
        check("result", 32'({res_sat, res_data}), 32'(exp_item));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [BW-1:0] a, input logic [BW-1:0] b);
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    a_in      = '0;
    b_in      = '0;
    in_valid  = 1'b0;
    acc_clr   = 1'b0;
    k_len     = KW'(1);
    res_ready = 1'b1;
    repeat (2) tick();
    check("reset_res_valid", 32'(res_valid), 0);
    check("reset_a_out", 32'(a_out), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_ovf_err", 32'(ovf_err), 0);
    rst = 1'b0;
    tick();

    // k=1: forwarding, latency and rounding/saturation.
    // 0.5*0.5 = 0.25
    exp_q.push_back({1'b0, 16'h2000});
    issue(16'h4000, 16'h4000);
    check("fwd_a_out", 32'(a_out), 32'h4000);
    check("fwd_out_valid", 32'(out_valid), 1);
    check("latency_t1_not_valid", 32'(res_valid), 0);
    idle(1);
    check("latency_t2_valid", 32'(res_valid), 1);
    // -1 * -1 = +1, clamps to 0x7FFF
    exp_q.push_back({1'b1, 16'h7FFF});
    issue(16'h8000, 16'h8000);
    // 2^14 + 2^14 -> 1 after >>15
    exp_q.push_back({1'b0, 16'h0001});
    issue(16'h0001, 16'h4000);
    // 16383 + 16384 = 32767 -> 0
    exp_q.push_back({1'b0, 16'h0000});
    issue(16'h0001, 16'h3FFF);
    // -16384 + 16384 = 0
    exp_q.push_back({1'b0, 16'h0000});
    issue(16'hFFFF, 16'h4000);
    idle(3);

    // k=4: four near-full-scale squares saturate.
    k_len = KW'(4);
    exp_q.push_back({1'b1, 16'h7FFF});
    for (int i = 0; i < 4; i++) issue(16'h7FFF, 16'h7FFF);
    idle(3);
    // 4 * 0.25*0.25 = 0.25
    exp_q.push_back({1'b0, 16'h2000});
    for (int i = 0; i < 4; i++) issue(16'h2000, 16'h2000);
    idle(3);

    // Same tile with gaps between operands.
    exp_q.push_back({1'b0, 16'h2000});
    issue(16'h2000, 16'h2000);
    idle(2);
    check("gap_busy_1", 32'(busy), 1);
    issue(16'h2000, 16'h2000);
    idle(2);
    issue(16'h2000, 16'h2000);
    idle(2);
    issue(16'h2000, 16'h2000);
    check("gap_busy_3", 32'(busy), 1);
    idle(1);
    check("gap_busy_done", 32'(busy), 0);
    check("gap_res_valid", 32'(res_valid), 1);
    idle(2);

    // Back-to-back k=2 tiles: 2*0.25 = 0.5, then 1/16 + 1/64 = 0x0A00.
    k_len = KW'(2);
    exp_q.push_back({1'b0, 16'h4000});
    exp_q.push_back({1'b0, 16'h0A00});
    issue(16'h4000, 16'h4000);
    issue(16'h4000, 16'h4000);
    issue(16'h2000, 16'h2000);
    check("b2b_first_valid", 32'(res_valid), 1);
    issue(16'h1000, 16'h1000);
    check("b2b_gap_cycle", 32'(res_valid), 0);
    check("b2b_no_bubble_busy", 32'(busy), 1);
    idle(1);
    check("b2b_second_valid", 32'(res_valid), 1);
    idle(2);

    // Backpressure: held result survives a dropped completion.
    k_len     = KW'(1);
    res_ready = 1'b0;
    exp_q.push_back({1'b0, 16'h2000});
    issue(16'h4000, 16'h4000);
    idle(2);
    check("bp_held_valid", 32'(res_valid), 1);
    check("bp_no_ovf_yet", 32'(ovf_err), 0);
    issue(16'h2000, 16'h2000);     // dropped: 0x0800
    idle(2);
    check("bp_held_data", 32'(res_data), 32'h2000);
    check("bp_ovf_set", 32'(ovf_err), 1);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    check("bp_clr_ovf", 32'(ovf_err), 0);
    check("bp_clr_keeps_valid", 32'(res_valid), 1);
    // Ready coincides with the next completion: 1/64 -> 0x0200.
    exp_q.push_back({1'b0, 16'h0200});
    issue(16'h1000, 16'h1000);
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    check("bp_refill_data", 32'(res_data), 32'h0200);
    check("bp_refill_no_ovf", 32'(ovf_err), 0);
    idle(2);

    // acc_clr while the 3rd product of a k=4 tile is in the MAC stage.
    k_len = KW'(4);
    for (int i = 0; i < 3; i++) issue(16'h7FFF, 16'h7FFF);
    in_valid = 1'b0;
    acc_clr  = 1'b1;
    tick();
    acc_clr = 1'b0;
    check("clr_busy", 32'(busy), 0);
    check("clr_no_result", 32'(res_valid), 0);
    exp_q.push_back({1'b0, 16'h2000});
    for (int i = 0; i < 4; i++) issue(16'h2000, 16'h2000);
    idle(3);

    // Async reset mid-tile with a held result (that result is discarded).
    k_len     = KW'(1);
    res_ready = 1'b0;
    issue(16'h4000, 16'h4000);
    idle(2);
    k_len = KW'(4);
    issue(16'h7FFF, 16'h7FFF);
    issue(16'h1234, 16'h5678);
    #2;
    rst = 1'b1;
    #1;
    check("rst_a_out", 32'(a_out), 0);
    check("rst_b_out", 32'(b_out), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_res_sat", 32'(res_sat), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_ovf_err", 32'(ovf_err), 0);
    check("rst_busy", 32'(busy), 0);
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    rst = 1'b0;
    idle(3);
    check("post_rst_idle", 32'(res_valid), 0);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
